mac_tx: RTL and testbench
=========================

// Module: mac_tx
// PURPOSE
//  Ethernet MAC transmit path: takes IPv4 payload beats from the IP layer and emits a full frame to the PCS.
//  Frame: preamble 7x55 + SFD D5 | dst 6B | src 6B | type 0x0800 | payload | zero pad | FCS 4B.
//  Drives the same PCS control sideband the receive path consumes (ctrl_v/start/term/idle).
//  Enforces the 46B minimum payload and a 12B inter-packet gap.
// PARAMETERS
//  DATA_W   16           datapath width (bits); only 16 supported
//  KEEP_W   DATA_W/8     byte-enable width
//  IPG_N    12           minimum idle bytes between frames
//  MIN_PL_N 46           minimum payload bytes; shorter frames are zero padded
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high reset
//  dst_addr_i   in   48      destination MAC, sampled at frame start
//  src_addr_i   in   48      source MAC, sampled at frame start
//  valid_i      in   1       IP layer beat valid
//  data_i       in   DATA_W  payload; data_i[15:8] is first byte on wire
//  keep_i       in   KEEP_W  byte enables, significant on last beat only (2'b11 or 2'b10)
//  last_i       in   1       last payload beat
//  ready_o      out  1       beat accepted when valid_i & ready_o
//  valid_o      out  1       PCS beat valid; high every cycle after reset
//  data_o       out  DATA_W  wire bytes; [15:8] first
//  ctrl_v_o     out  1       control beat (start/term/idle/err)
//  idle_o       out  1       idle beat
//  start_o      out  1       start of frame; first preamble beat
//  term_o       out  1       last beat of frame
//  term_keep_o  out  KEEP_W  valid bytes on term beat
//  err_o        out  1       frame aborted (underrun)
// BEHAVIOUR
//  Reset: state IDLE, IPG counter = IPG_N (gap already satisfied), ready_o=0, valid_o=0,
//   ctrl_v_o=1, idle_o=1, start_o=term_o=err_o=0, data_o=0, term_keep_o=0.
//   Reset mid-frame drops the frame immediately; no term is emitted.
//  FSM: IDLE->PRE->HEAD->DATA->(PAD)->FCS->IPG->IDLE; DATA->DROP->IPG on underrun.
//  IDLE: ctrl_v_o=idle_o=1. valid_i=1 and gap met -> PRE next cycle; latch dst/src.
//  PRE: 4 beats 5555,5555,5555,55D5; start_o=ctrl_v_o=1 on first only.
//  HEAD: 7 beats: dst (3), src (3), 0800 (1); MSB byte of each field first.
//  DATA: ready_o=1 combinationally; each accepted beat is forwarded next cycle.
//   Byte counter saturates at MIN_PL_N.
//  Underrun: valid_i=0 in DATA -> emit one beat with ctrl_v_o=err_o=term_o=1, term_keep_o=0.
//   Then enter DROP: ready_o=1, beats discarded through last_i, then IPG.
//  PAD: after last_i, if payload <MIN_PL_N send 00 bytes up to 46 (odd tail byte padded in same beat).
//  FCS: CRC-32 (poly 04C11DB7, reflected, init FFFFFFFF, final xor FFFFFFFF) over dst..pad.
//   Sent LS byte first. CRC is updated 2 bytes/cycle, 1 byte on 2'b10 beats.
//   Even byte count: 2 FCS beats; term on second with term_keep_o=11.
//   Odd byte count: last data byte shares beat with FCS[7:0], then FCS[15:8],FCS[23:16],
//    then FCS[31:24] on term beat with term_keep_o=10.
//  term_o beat has ctrl_v_o=1. IPG counts bytes after the term beat;
//   unused bytes of the term beat count toward the gap. Next start no earlier than gap met.
//  valid_i in IDLE before gap met: ready_o=0, held off; no beat lost.
//  last_i with keep_i=10 on a non-padded frame: odd FCS path. keep_i ignored when last_i=0.
// CONFIGURATION
//  MAC_TX_VLAN_EN defined: adds vlan_tci_i (in, 16) port, sampled at frame start.
//   Inserts 4B tag 8100|tci after src; HEAD is 9 beats; tag covered by FCS; MIN_PL_N unchanged.
//  Undefined: no port, no tag, HEAD is 7 beats.
// TESTING
//  1. Reset, hold valid_i=0 -> idle_o=1 every cycle; ready_o=0; start_o never set.
//  2. 46B payload, dst FFFFFFFFFFFF, src 020000000001 -> start at cycle +1; 4 PRE, 7 HEAD, 23 DATA, 2 FCS beats.
//     term_keep_o=11; FCS matches reference CRC model.
//  3. 1B payload AB (keep 10) -> AB00 then 22 zero beats (pad 46).
//     FCS on 2 beats, term_keep_o=11.
//  4. 47B payload -> odd path: last beat {byte47,FCS0}; term beat term_keep_o=10.
//  5. Back-to-back frames, valid_i held -> gap >=12 bytes between term and next start_o.
//  6. valid_i drops mid-DATA -> err_o=term_o=1 one cycle.
//     Remaining beats absorbed until last_i; next frame starts after IPG.
//     With MAC_TX_VLAN_EN, tci=0005: bytes 81 00 00 05 precede 0800.

Source files
------------

// File: rtl/mac_tx.sv
// mac_tx: Ethernet MAC transmit path.
// Wraps IPv4 payload beats from the IP layer into a complete Ethernet frame:
// preamble/SFD, destination and source MAC, EtherType 0x0800, payload,
// zero pad up to MIN_PL_N bytes, and the CRC-32 FCS. The PCS control
// sideband (ctrl_v/idle/start/term/err) is driven alongside the data.
// An IPG_N-byte gap is enforced between frames.
//
// Optional build macro: MAC_TX_VLAN_EN adds vlan_tci_i and inserts an
// 802.1Q tag (8100 + TCI) after the source address.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   dst_addr_i       destination MAC, sampled at frame start
//   src_addr_i       source MAC, sampled at frame start
//   vlan_tci_i       VLAN TCI, sampled at frame start (MAC_TX_VLAN_EN only)
//   valid_i/ready_o  payload handshake; data_i[15:8] is first on the wire
//   keep_i, last_i   byte enables (last beat only) and end of payload
//   valid_o          PCS beat valid, high every cycle after reset
//   data_o           wire bytes, [15:8] first
//   ctrl_v_o, idle_o, start_o, term_o, term_keep_o, err_o  PCS sideband
module mac_tx #(
    parameter int DATA_W   = 16,
    parameter int KEEP_W   = DATA_W / 8,
    parameter int IPG_N    = 12,
    parameter int MIN_PL_N = 46
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [47:0]       dst_addr_i,
    input  logic [47:0]       src_addr_i,
`ifdef MAC_TX_VLAN_EN
    input  logic [15:0]       vlan_tci_i,
`endif
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  logic              last_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              ctrl_v_o,
    output logic              idle_o,
    output logic              start_o,
    output logic              term_o,
    output logic [KEEP_W-1:0] term_keep_o,
    output logic              err_o
);

    localparam logic [7:0] GAP_MAX = 8'(IPG_N);
    localparam logic [6:0] MIN_PL  = 7'(MIN_PL_N);
`ifdef MAC_TX_VLAN_EN
    localparam int HEAD_N = 9;
`else
    localparam int HEAD_N = 7;
`endif
    localparam int         HDR_W     = HEAD_N * 16;
    localparam logic [3:0] HEAD_LAST = 4'(HEAD_N - 1);

    typedef enum logic [2:0] {IDLE, PRE, HEAD, DATA, PAD, FCS, IPG, DROP} state_t;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [31:0]      crc_reg, crc_next;
    logic [6:0]       pl_reg, pl_next;
    logic [7:0]       gap_reg, gap_next;
    logic [HDR_W-1:0] hdr_reg, hdr_next;
    logic             odd_reg, odd_next;

    logic [15:0]      data_next;
    logic             ctrl_v_next, idle_next, start_next, term_next, err_next;
    logic [1:0]       keep_next;

    logic [HDR_W-1:0] hdr_load;
    logic             odd_tail;
    logic [7:0]       lo_byte;
    logic [15:0]      crc_word;
    logic [31:0]      crc_one, crc_two, fcs;
    logic [6:0]       pl_one, pl_two, pl_two_sat;
    logic [7:0]       gap_inc;

`ifdef MAC_TX_VLAN_EN
    assign hdr_load = {dst_addr_i, src_addr_i, 16'h8100, vlan_tci_i, 16'h0800};
`else
    assign hdr_load = {dst_addr_i, src_addr_i, 16'h0800};
`endif

    // A single-byte last beat; when padding follows, its unused byte
    // becomes the first pad byte so the payload stays beat aligned.
    assign odd_tail = last_i && (keep_i == 2'b10);
    assign lo_byte  = odd_tail ? 8'h00 : data_i[7:0];

    always_comb begin
        crc_word = {data_i[15:8], lo_byte};
        if (state_reg == HEAD)
            crc_word = hdr_reg[HDR_W-1 -: 16];
        else if (state_reg == PAD)
            crc_word = 16'h0000;
    end

    assign crc_one    = crc_byte(crc_reg, crc_word[15:8]);
    assign crc_two    = crc_byte(crc_one, crc_word[7:0]);
    assign fcs        = ~crc_reg;
    assign pl_one     = pl_reg + 7'd1;
    assign pl_two     = pl_reg + 7'd2;
    assign pl_two_sat = (pl_two > MIN_PL) ? MIN_PL : pl_two;
    assign gap_inc    = (gap_reg >= GAP_MAX) ? gap_reg : gap_reg + 8'd2;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        crc_next    = crc_reg;
        pl_next     = pl_reg;
        gap_next    = gap_reg;
        hdr_next    = hdr_reg;
        odd_next    = odd_reg;
        data_next   = 16'h0000;
        ctrl_v_next = 1'b0;
        idle_next   = 1'b0;
        start_next  = 1'b0;
        term_next   = 1'b0;
        err_next    = 1'b0;
        keep_next   = 2'b00;
        ready_o     = 1'b0;

        case (state_reg)
            IDLE: begin
                ctrl_v_next = 1'b1;
                idle_next   = 1'b1;
                gap_next    = gap_inc;
                if (valid_i && (gap_reg >= GAP_MAX)) begin
                    // First preamble beat goes out on the next cycle.
                    idle_next  = 1'b0;
                    start_next = 1'b1;
                    data_next  = 16'h5555;
                    hdr_next   = hdr_load;
                    crc_next   = 32'hFFFFFFFF;
                    pl_next    = 7'd0;
                    cnt_next   = 4'd1;
                    state_next = PRE;
                end
            end
            PRE: begin
                data_next = (cnt_reg == 4'd3) ? 16'h55D5 : 16'h5555;
                cnt_next  = cnt_reg + 4'd1;
                if (cnt_reg == 4'd3) begin
                    cnt_next   = 4'd0;
                    state_next = HEAD;
                end
            end
            HEAD: begin
                data_next = hdr_reg[HDR_W-1 -: 16];
                hdr_next  = hdr_reg << 16;
                crc_next  = crc_two;
                cnt_next  = cnt_reg + 4'd1;
                if (cnt_reg == HEAD_LAST)
                    state_next = DATA;
            end
            DATA: begin
                ready_o = !reset;
                if (!valid_i) begin
                    // Underrun: abort frame, then swallow the rest of it.
                    ctrl_v_next = 1'b1;
                    term_next   = 1'b1;
                    err_next    = 1'b1;
                    gap_next    = 8'd2;
                    state_next  = DROP;
                end else if (odd_tail && (pl_one >= MIN_PL)) begin
                    // Odd unpadded tail: FCS byte 0 shares the beat.
                    data_next  = {data_i[15:8], ~crc_one[7:0]};
                    crc_next   = crc_one;
                    odd_next   = 1'b1;
                    cnt_next   = 4'd0;
                    state_next = FCS;
                end else begin
                    data_next = {data_i[15:8], lo_byte};
                    crc_next  = crc_two;
                    pl_next   = pl_two_sat;
                    if (last_i) begin
                        odd_next   = 1'b0;
                        cnt_next   = 4'd0;
                        state_next = (pl_two < MIN_PL) ? PAD : FCS;
                    end
                end
            end
            PAD: begin
                crc_next = crc_two;
                pl_next  = pl_two;
                if (pl_two >= MIN_PL) begin
                    odd_next   = 1'b0;
                    cnt_next   = 4'd0;
                    state_next = FCS;
                end
            end
            FCS: begin
                cnt_next = cnt_reg + 4'd1;
                if (cnt_reg == 4'd0) begin
                    data_next = odd_reg ? {fcs[15:8], fcs[23:16]} : {fcs[7:0], fcs[15:8]};
                end else begin
                    data_next   = odd_reg ? {fcs[31:24], 8'h00} : {fcs[23:16], fcs[31:24]};
                    ctrl_v_next = 1'b1;
                    term_next   = 1'b1;
                    keep_next   = odd_reg ? 2'b10 : 2'b11;
                    // The unused byte of an odd term beat is already gap.
                    gap_next    = odd_reg ? 8'd1 : 8'd0;
                    state_next  = IPG;
                end
            end
            IPG: begin
                ctrl_v_next = 1'b1;
                idle_next   = 1'b1;
                gap_next    = gap_inc;
                if (gap_inc >= GAP_MAX)
                    state_next = IDLE;
            end
            DROP: begin
                ready_o     = !reset;
                ctrl_v_next = 1'b1;
                idle_next   = 1'b1;
                gap_next    = gap_inc;
                if (valid_i && last_i)
                    state_next = IPG;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            crc_reg     <= 32'hFFFFFFFF;
            pl_reg      <= 7'd0;
            gap_reg     <= GAP_MAX;
            hdr_reg     <= '0;
            odd_reg     <= 1'b0;
            valid_o     <= 1'b0;
            data_o      <= '0;
            ctrl_v_o    <= 1'b1;
            idle_o      <= 1'b1;
            start_o     <= 1'b0;
            term_o      <= 1'b0;
            err_o       <= 1'b0;
            term_keep_o <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            crc_reg     <= crc_next;
            pl_reg      <= pl_next;
            gap_reg     <= gap_next;
            hdr_reg     <= hdr_next;
            odd_reg     <= odd_next;
            valid_o     <= 1'b1;
            data_o      <= data_next;
            ctrl_v_o    <= ctrl_v_next;
            idle_o      <= idle_next;
            start_o     <= start_next;
            term_o      <= term_next;
            err_o       <= err_next;
            term_keep_o <= keep_next;
        end
    end

endmodule

// File: tb/tb_mac_tx.sv
// tb_mac_tx: bench for mac_tx. Frames are built byte by byte from the
// Ethernet frame format, FCS computed with the MSB-first CRC-32 definition,
// and the expected PCS beats are queued for the output monitor.
module tb_mac_tx;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [15:0] data;
        logic        start;
        logic        term;
        logic        err;
        logic [1:0]  keep;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] dst_addr_i, src_addr_i;
`ifdef MAC_TX_VLAN_EN
    logic [15:0] vlan_tci_i;
`endif
    logic        valid_i;
    logic [15:0] data_i;
    logic [1:0]  keep_i;
    logic        last_i;
    logic        ready_o, valid_o, ctrl_v_o, idle_o, start_o, term_o, err_o;
    logic [15:0] data_o;
    logic [1:0]  term_keep_o;

    mac_tx dut (
        .clk         (clk),
        .reset       (reset),
        .dst_addr_i  (dst_addr_i),
        .src_addr_i  (src_addr_i),
`ifdef MAC_TX_VLAN_EN
        .vlan_tci_i  (vlan_tci_i),
`endif
        .valid_i     (valid_i),
        .data_i      (data_i),
        .keep_i      (keep_i),
        .last_i      (last_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .ctrl_v_o    (ctrl_v_o),
        .idle_o      (idle_o),
        .start_o     (start_o),
        .term_o      (term_o),
        .term_keep_o (term_keep_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    exp_start_cyc = -1;
    int    gap_bytes = 0;
    bit    have_term = 1'b0;
    bit    in_frame  = 1'b0;
    bit    mon_en    = 1'b0;
    beat_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Ethernet FCS from the plain definition: MSB-first shift register,
    // bytes fed LSB first, result bit-reversed and inverted.
    function automatic logic [31:0] ref_fcs(input byte_q_t bytes);
        logic [31:0] c;
        logic [31:0] r;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (bytes[n]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[31] ^ bytes[n][i];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        for (int i = 0; i < 32; i++) r[i] = c[31-i];
        return ~r;
    endfunction

    function automatic byte_q_t rand_payload(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic drive_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
        bit ok;
        ok      = 1'b0;
        valid_i = 1'b1;
        data_i  = d;
        keep_i  = k;
        last_i  = l;
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            if (ready_o) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL handshake: ready_o never seen, got 0 required 1 (cyc %0d)", cyc);
        end
    endtask

    // uk >= 0: drop valid_i after uk accepted beats (underrun).
    task automatic send_frame(input byte_q_t pl, input int uk, input bit lat,
                              input logic [47:0] d, input logic [47:0] s);
        byte_q_t     fr, w;
        logic [31:0] f;
        beat_t       b;
        int          nbeats, np;
        logic [7:0]  lo;
        for (int i = 5; i >= 0; i--) fr.push_back(d[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) fr.push_back(s[i*8 +: 8]);
`ifdef MAC_TX_VLAN_EN
        fr.push_back(8'h81);
        fr.push_back(8'h00);
        fr.push_back(vlan_tci_i[15:8]);
        fr.push_back(vlan_tci_i[7:0]);
`endif
        fr.push_back(8'h08);
        fr.push_back(8'h00);
        if (uk < 0) begin
            foreach (pl[i]) fr.push_back(pl[i]);
            for (int i = pl.size(); i < 46; i++) fr.push_back(8'h00);
            f = ref_fcs(fr);
            fr.push_back(f[7:0]);
            fr.push_back(f[15:8]);
            fr.push_back(f[23:16]);
            fr.push_back(f[31:24]);
        end else begin
            for (int i = 0; i < 2*uk; i++) fr.push_back(pl[i]);
        end
        for (int i = 0; i < 7; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        foreach (fr[i]) w.push_back(fr[i]);
        for (int i = 0; i < w.size(); i += 2) begin
            b.data  = {w[i], (i + 1 < w.size()) ? w[i+1] : 8'h00};
            b.start = (i == 0);
            b.term  = (uk < 0) && (i + 2 >= w.size());
            b.err   = 1'b0;
            b.keep  = b.term ? ((i + 1 < w.size()) ? 2'b11 : 2'b10) : 2'b00;
            exp_q.push_back(b);
        end
        if (uk >= 0) begin
            b = '{data: 16'h0000, start: 1'b0, term: 1'b1, err: 1'b1, keep: 2'b00};
            exp_q.push_back(b);
        end

        dst_addr_i = d;
        src_addr_i = s;
        np     = pl.size();
        nbeats = (np + 1) / 2;
        for (int k = 0; k < nbeats; k++) begin
            if (k == uk && uk >= 0) begin
                valid_i = 1'b0;
                @(posedge clk);
                #1;
            end
            lo = (2*k + 1 < np) ? pl[2*k+1] : 8'($urandom);
            if (k == 0 && lat) exp_start_cyc = cyc + 1;
            if (k == nbeats - 1)
                drive_beat({pl[2*k], lo}, (np % 2 == 1) ? 2'b10 : 2'b11, 1'b1);
            else
                drive_beat({pl[2*k], lo}, 2'($urandom), 1'b0);
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    always @(negedge clk) begin
        beat_t       e;
        logic [15:0] mask;
        if (mon_en) begin
            total++;
            if (!valid_o) begin
                bad++;
                $display("FAIL valid_o: got 0 required 1 (cyc %0d)", cyc);
            end
            if (idle_o) begin
                total++;
                if (in_frame) begin
                    bad++;
                    $display("FAIL idle_in_frame: got idle_o=1 required frame beat (cyc %0d)", cyc);
                end
                gap_bytes += 2;
            end else if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got d=%h start=%b term=%b required idle (cyc %0d)",
                         data_o, start_o, term_o, cyc);
            end else begin
                e = exp_q.pop_front();
                if (!e.term)              mask = 16'hFFFF;
                else if (e.keep == 2'b11) mask = 16'hFFFF;
                else if (e.keep == 2'b10) mask = 16'hFF00;
                else                      mask = 16'h0000;
                total++;
                if (((data_o & mask) !== (e.data & mask)) ||
                    ({start_o, term_o, err_o, ctrl_v_o, term_keep_o} !==
                     {e.start, e.term, e.err, e.start | e.term, e.keep})) begin
                    bad++;
                    $display("FAIL beat: got d=%h s=%b t=%b e=%b c=%b k=%b required d=%h s=%b t=%b e=%b c=%b k=%b (cyc %0d)",
                             data_o, start_o, term_o, err_o, ctrl_v_o, term_keep_o,
                             e.data, e.start, e.term, e.err, e.start | e.term, e.keep, cyc);
                end
                if (e.start) begin
                    in_frame = 1'b1;
                    if (have_term) begin
                        total++;
                        if (gap_bytes < 12) begin
                            bad++;
                            $display("FAIL ipg: got %0d gap bytes required >=12 (cyc %0d)", gap_bytes, cyc);
                        end
                    end
                    if (exp_start_cyc >= 0) begin
                        total++;
                        if (cyc != exp_start_cyc) begin
                            bad++;
                            $display("FAIL start_latency: got cyc %0d required cyc %0d", cyc, exp_start_cyc);
                        end
                        exp_start_cyc = -1;
                    end
                end
                if (e.term) begin
                    in_frame  = 1'b0;
                    have_term = 1'b1;
                    gap_bytes = (e.keep == 2'b11) ? 0 : (e.keep == 2'b10) ? 1 : 2;
                end
                $display("beat d=%h s=%b t=%b e=%b k=%b", data_o, start_o, term_o, err_o, term_keep_o);
            end
        end
    end

    initial begin
        byte_q_t pl;
        int      n, uk;
        reset      = 1'b1;
        valid_i    = 1'b0;
        data_i     = 16'h0000;
        keep_i     = 2'b11;
        last_i     = 1'b0;
        dst_addr_i = 48'h0;
        src_addr_i = 48'h0;
`ifdef MAC_TX_VLAN_EN
        vlan_tci_i = 16'h0005;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({valid_o, ctrl_v_o, idle_o, start_o, term_o, err_o, ready_o} !== 7'b0110000 ||
            data_o !== 16'h0000 || term_keep_o !== 2'b00) begin
            bad++;
            $display("FAIL reset_state: got v=%b c=%b i=%b s=%b t=%b e=%b r=%b d=%h k=%b required v=0 c=1 i=1 s=0 t=0 e=0 r=0 d=0000 k=00",
                     valid_o, ctrl_v_o, idle_o, start_o, term_o, err_o, ready_o, data_o, term_keep_o);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;

        // Idle with no traffic.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (!idle_o || start_o || ready_o) begin
                bad++;
                $display("FAIL idle_hold: got idle=%b start=%b ready=%b required 1 0 0", idle_o, start_o, ready_o);
            end
        end
        @(posedge clk);
        #1;

        // 46-byte payload, broadcast dst.
        pl = rand_payload(46);
        send_frame(pl, -1, 1'b1, 48'hFFFFFFFFFFFF, 48'h020000000001);
        repeat (20) @(posedge clk);
        #1;

        // 1-byte payload, padded.
        pl = {};
        pl.push_back(8'hAB);
        send_frame(pl, -1, 1'b0, 48'h0A0B0C0D0E0F, 48'h020000000001);
        repeat (20) @(posedge clk);
        #1;

        // 47-byte payload, odd FCS alignment.
        pl = rand_payload(47);
        send_frame(pl, -1, 1'b0, 48'h112233445566, 48'h020000000002);

        // Back-to-back frames, valid_i never dropped in between.
        for (int f = 0; f < 3; f++) begin
            pl = rand_payload($urandom_range(1, 70));
            send_frame(pl, -1, 1'b0, {16'h0001, 32'($urandom)}, {16'h0200, 32'($urandom)});
        end

        // Underrun mid-payload, then the next frame right behind it.
        pl = rand_payload(60);
        send_frame(pl, 5, 1'b0, 48'hFFFFFFFFFFFF, 48'h020000000003);
        pl = rand_payload(45);
        send_frame(pl, -1, 1'b0, 48'h00AA00BB00CC, 48'h020000000004);

        // Random mix.
        for (int f = 0; f < 12; f++) begin
`ifdef MAC_TX_VLAN_EN
            vlan_tci_i = 16'($urandom);
`endif
            n  = $urandom_range(4, 100);
            uk = -1;
            if ($urandom_range(0, 3) == 0) uk = $urandom_range(1, (n + 1) / 2 - 1);
            pl = rand_payload(n);
            send_frame(pl, uk, 1'b0, {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)});
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        for (int w = 0; w < 2000 && exp_q.size() != 0; w++) @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d beats outstanding required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
